bsg_dram_channel_req_arbiter: RTL and testbench

- Shares one read-only dramsim3 channel request port among num_req_p requesters.
- Round-robin arbitration with a held (locked) grant.
- Caps in-flight reads at max_outstanding_p.
- Routes each returning read-data beat to the requester that issued it, using an in-order tag FIFO. The channel returns reads in issue order.
- Sits between per-requester trace/test masters and one channel of bsg_nonsynth_dramsim3.

---
 rtl/bsg_dram_channel_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bsg_dram_channel_req_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_dram_channel_req_arbiter.sv
// Shares one read-only dramsim3 channel request port among num_req_p
// requesters. Round-robin arbitration with a held grant, a cap on in-flight
// reads, and an in-order tag FIFO that steers each returned beat back to
// the requester that issued it.
module bsg_dram_channel_req_arbiter #(
  parameter int num_req_p            = 4,
  parameter int channel_addr_width_p = 29,
  parameter int max_outstanding_p    = 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic [num_req_p-1:0]                        v_i,
  input  logic [num_req_p*channel_addr_width_p-1:0]   ch_addr_i,
  output logic [num_req_p-1:0]                        yumi_o,
  output logic                                        dram_v_o,
  output logic [channel_addr_width_p-1:0]             dram_ch_addr_o,
  input  logic                                        dram_yumi_i,
  input  logic                                        dram_data_v_i,
  output logic [num_req_p-1:0]                        data_v_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]      outstanding_o,
  output logic                                        idle_o,
  output logic                                        error_o
);

  localparam int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
  localparam int fptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  localparam logic [cnt_w_lp-1:0]  max_cnt_lp   = cnt_w_lp'(max_outstanding_p);
  localparam logic [id_w_lp-1:0]   last_id_lp   = id_w_lp'(num_req_p - 1);
  localparam logic [fptr_w_lp-1:0] last_fptr_lp = fptr_w_lp'(max_outstanding_p - 1);

  typedef enum logic {
    e_arb,
    e_lock
  } state_e;

  state_e                 state_q, state_d;
  logic [id_w_lp-1:0]     ptr_q, ptr_d;
  logic [id_w_lp-1:0]     lock_q, lock_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [fptr_w_lp-1:0]   wr_q, wr_d;
  logic [fptr_w_lp-1:0]   rd_q, rd_d;
  logic                   error_q, error_d;
  logic [id_w_lp-1:0]     tag_q [max_outstanding_p];

  logic [id_w_lp-1:0]     winner;
  logic [id_w_lp-1:0]     grant;
  logic                   any_v;
  logic                   credit_ok;
  logic                   accept;
  logic                   empty;
  logic                   pop;

  // Round-robin search: first set v_i at or after ptr_q, with wrap-around.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && v_i[id_w_lp'(idx)]) begin
        found  = 1'b1;
        winner = id_w_lp'(idx);
      end
    end
  end

  // Request side: channel valid, address mux and per-requester accept.
  // dram_v_o is gated by reset so outputs clear the moment reset asserts,
  // even though the ARB-state valid is a combinational function of v_i.
  always_comb begin
    any_v          = |v_i;
    credit_ok      = (cnt_q < max_cnt_lp);
    grant          = (state_q == e_lock) ? lock_q : winner;
    dram_v_o       = reset_n_i & ((state_q == e_lock) | (any_v & credit_ok));
    accept         = dram_yumi_i & dram_v_o;
    dram_ch_addr_o = '0;
    yumi_o         = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant == id_w_lp'(i)) begin
        dram_ch_addr_o = ch_addr_i[i*channel_addr_width_p +: channel_addr_width_p];
        yumi_o[i]      = accept;
      end
    end
  end

  // Return side: steer the beat to the FIFO head, flag returns with no tracker.
  always_comb begin
    empty    = (cnt_q == '0);
    pop      = dram_data_v_i & ~empty;
    data_v_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      data_v_o[i] = pop & (tag_q[rd_q] == id_w_lp'(i));
    end
    error_d       = error_q | (dram_data_v_i & empty);
    outstanding_o = cnt_q;
    idle_o        = empty & ~dram_v_o;
    error_o       = error_q;
  end

  // Arbiter FSM next-state: lock the winner until the channel accepts.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      e_arb: begin
        if (any_v && credit_ok && !dram_yumi_i) begin
          state_d = e_lock;
          lock_d  = winner;
        end
      end
      e_lock: begin
        if (dram_yumi_i) state_d = e_arb;
      end
      default: state_d = e_arb;
    endcase
  end

  // Pointer, tag FIFO pointers and outstanding count updates.
  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (accept) begin
      ptr_d = (grant == last_id_lp) ? '0 : grant + id_w_lp'(1);
      wr_d  = (wr_q == last_fptr_lp) ? '0 : wr_q + fptr_w_lp'(1);
    end
    if (pop) begin
      rd_d = (rd_q == last_fptr_lp) ? '0 : rd_q + fptr_w_lp'(1);
    end
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_arb;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      error_q <= error_d;
    end
  end

  // Tag storage; validity is tracked by the pointers and count, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) tag_q[wr_q] <= grant;
  end

endmodule

// File: tb/tb_bsg_dram_channel_req_arbiter.sv
// Directed bench for bsg_dram_channel_req_arbiter with a scoreboard: stimulus
// pushes expected grants/returns, a negedge monitor pops and compares.
module tb_bsg_dram_channel_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 29;
  localparam int MO = 8;
  localparam int CW = $clog2(MO + 1);

  logic                 clk;
  logic                 reset_n;
  logic [NR-1:0]        v_i;
  logic [NR*AW-1:0]     ch_addr_i;
  logic [NR-1:0]        yumi_o;
  logic                 dram_v_o;
  logic [AW-1:0]        dram_ch_addr_o;
  logic                 dram_yumi_i;
  logic                 dram_data_v_i;
  logic [NR-1:0]        data_v_o;
  logic [CW-1:0]        outstanding_o;
  logic                 idle_o;
  logic                 error_o;

  int checks = 0;
  int errors = 0;
  int exp_g[$];
  int exp_r[$];

  bsg_dram_channel_req_arbiter #(
    .num_req_p(NR),
    .channel_addr_width_p(AW),
    .max_outstanding_p(MO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .v_i(v_i),
    .ch_addr_i(ch_addr_i),
    .yumi_o(yumi_o),
    .dram_v_o(dram_v_o),
    .dram_ch_addr_o(dram_ch_addr_o),
    .dram_yumi_i(dram_yumi_i),
    .dram_data_v_i(dram_data_v_i),
    .data_v_o(data_v_o),
    .outstanding_o(outstanding_o),
    .idle_o(idle_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int r);
    return AW'(29'h0ABC000 + r * 29'h111);
  endfunction

  function automatic logic [NR-1:0] onehot(input int r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: every accept and every returned beat must match the
  // head of the corresponding expectation queue.
  always @(negedge clk) begin
    int g;
    if (yumi_o != '0) begin
      if (exp_g.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_yumi: actual %b required none", yumi_o);
      end else begin
        g = exp_g.pop_front();
        check("yumi_onehot", 64'(yumi_o), 64'(onehot(g)));
        check("grant_addr", 64'(dram_ch_addr_o), 64'(addr_of(g)));
      end
    end
    if (data_v_o != '0) begin
      if (exp_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_v: actual %b required none", data_v_o);
      end else begin
        g = exp_r.pop_front();
        check("data_v_onehot", 64'(data_v_o), 64'(onehot(g)));
      end
    end
  end

  initial begin
    int drain[8];
    int seq3[3];

    reset_n       = 1'b0;
    v_i           = '0;
    dram_yumi_i   = 1'b0;
    dram_data_v_i = 1'b0;
    for (int i = 0; i < NR; i++) ch_addr_i[i*AW +: AW] = addr_of(i);

    // Reset state
    #2;
    check("rst_dram_v", 64'(dram_v_o), 64'd0);
    check("rst_yumi", 64'(yumi_o), 64'd0);
    check("rst_data_v", 64'(data_v_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    #10;
    reset_n = 1'b1;
    tick();

    // Round-robin fill to the credit limit
    for (int i = 0; i < 8; i++) exp_g.push_back(i % 4);
    v_i = 4'b1111;
    dram_yumi_i = 1'b1;
    repeat (8) tick();
    check("full_dram_v", 64'(dram_v_o), 64'd0);
    check("full_outstanding", 64'(outstanding_o), 64'd8);

    // At the limit: return frees a credit but no grant is formed this cycle
    exp_r.push_back(0);
    dram_data_v_i = 1'b1;
    @(negedge clk);
    check("full_no_grant", 64'(dram_v_o), 64'd0);
    tick();
    check("after_pop_outstanding", 64'(outstanding_o), 64'd7);

    // Same-cycle accept and return leaves the count unchanged
    exp_g.push_back(2);
    exp_r.push_back(1);
    v_i = 4'b0100;
    tick();
    check("accept_and_pop_outstanding", 64'(outstanding_o), 64'd7);

    // Pointer at 3 wraps to requester 0
    exp_g.push_back(0);
    v_i = 4'b0001;
    dram_data_v_i = 1'b0;
    tick();
    check("refill_outstanding", 64'(outstanding_o), 64'd8);
    v_i = '0;
    dram_yumi_i = 1'b0;

    // Drain: FIFO order must survive the push/pop overlap
    drain = '{2, 3, 0, 1, 2, 3, 2, 0};
    dram_data_v_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_r.push_back(drain[i]);
      tick();
    end
    dram_data_v_i = 1'b0;
    check("drain_outstanding", 64'(outstanding_o), 64'd0);
    check("drain_idle", 64'(idle_o), 64'd1);

    // Held grant across a stall; a late v_i[1] must not steal it
    reset_pulse();
    v_i = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) v_i = 4'b0111;
      if (k == 5) begin
        v_i = 4'b0101;
        dram_yumi_i = 1'b1;
        exp_g.push_back(0);
      end
      @(negedge clk);
      check("stall_dram_v", 64'(dram_v_o), 64'd1);
      check("stall_addr", 64'(dram_ch_addr_o), 64'(addr_of(0)));
      tick();
    end
    exp_g.push_back(2);
    tick();
    v_i = '0;
    dram_yumi_i = 1'b0;
    check("stall_outstanding", 64'(outstanding_o), 64'd2);
    dram_data_v_i = 1'b1;
    exp_r.push_back(0);
    tick();
    exp_r.push_back(2);
    tick();
    dram_data_v_i = 1'b0;
    check("stall_drain_outstanding", 64'(outstanding_o), 64'd0);

    // Issue 2,0,3 then route the three returns in that order
    seq3 = '{2, 0, 3};
    dram_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v_i = onehot(seq3[i]);
      exp_g.push_back(seq3[i]);
      tick();
    end
    v_i = '0;
    dram_yumi_i = 1'b0;
    check("route_outstanding", 64'(outstanding_o), 64'd3);
    dram_data_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_r.push_back(seq3[i]);
      tick();
      check("route_count", 64'(outstanding_o), 64'(2 - i));
    end
    dram_data_v_i = 1'b0;
    check("route_idle", 64'(idle_o), 64'd1);
    check("route_no_error", 64'(error_o), 64'd0);

    // Return with an empty tracker: no beat steered, sticky error
    dram_data_v_i = 1'b1;
    @(negedge clk);
    check("empty_ret_data_v", 64'(data_v_o), 64'd0);
    tick();
    dram_data_v_i = 1'b0;
    check("empty_ret_error", 64'(error_o), 64'd1);
    v_i = 4'b0010;
    dram_yumi_i = 1'b1;
    exp_g.push_back(1);
    tick();
    v_i = '0;
    dram_yumi_i = 1'b0;
    exp_r.push_back(1);
    dram_data_v_i = 1'b1;
    tick();
    dram_data_v_i = 1'b0;
    check("error_sticky", 64'(error_o), 64'd1);
    check("error_traffic_outstanding", 64'(outstanding_o), 64'd0);

    // Asynchronous reset with five reads in flight and a pending grant
    reset_pulse();
    for (int i = 0; i < 5; i++) exp_g.push_back(i % 4);
    v_i = 4'b1111;
    dram_yumi_i = 1'b1;
    repeat (5) tick();
    dram_yumi_i = 1'b0;
    check("pre_reset_outstanding", 64'(outstanding_o), 64'd5);
    #2;
    check("pre_reset_dram_v", 64'(dram_v_o), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_dram_v", 64'(dram_v_o), 64'd0);
    check("async_rst_yumi", 64'(yumi_o), 64'd0);
    check("async_rst_outstanding", 64'(outstanding_o), 64'd0);
    check("async_rst_idle", 64'(idle_o), 64'd1);
    check("async_rst_error", 64'(error_o), 64'd0);
    v_i = '0;
    reset_n = 1'b1;
    tick();
    dram_data_v_i = 1'b1;
    tick();
    dram_data_v_i = 1'b0;
    check("post_rst_return_error", 64'(error_o), 64'd1);
    v_i = 4'b1111;
    dram_yumi_i = 1'b1;
    exp_g.push_back(0);
    tick();
    v_i = '0;
    dram_yumi_i = 1'b0;
    check("post_rst_outstanding", 64'(outstanding_o), 64'd1);
    exp_r.push_back(0);
    dram_data_v_i = 1'b1;
    tick();
    dram_data_v_i = 1'b0;
    check("final_outstanding", 64'(outstanding_o), 64'd0);
    tick();

    check("exp_grants_left", 64'(exp_g.size()), 64'd0);
    check("exp_returns_left", 64'(exp_r.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
